seq_det_param_mealy: RTL and testbench
======================================

SEQ_DET_PARAM_MEALY -- requirements
Module: seq_det_param_mealy

Interface
REQ-001 Parameter PAT_LEN, default 5: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 5'b10110, PAT_LEN bits wide: target sequence; PATTERN[PAT_LEN-1] is the first bit received.
REQ-003 Parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: in_seq holds a valid bit this cycle.
REQ-007 Port in_seq, input, 1 bit: serial data bit.
REQ-008 Port overlap_en, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-009 Port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-010 Port det_out, output, 1 bit: Mealy detect pulse.
REQ-011 Port match_cnt, output, CNT_W bits: saturating count of detections.
REQ-012 Port state_out, output, $clog2(PAT_LEN) bits: current matched-prefix length, for debug.

Function
REQ-013 State encoding: state S holds the number of pattern bits currently matched, range 0..PAT_LEN-1.
REQ-014 det_out is combinational and equals in_valid AND (S==PAT_LEN-1) AND (in_seq==PATTERN[0]); there is no added latency.
REQ-015 When in_valid=0: S holds, det_out=0, match_cnt holds unless cnt_clr=1.
REQ-016 On a valid bit that extends the match without completing it, the next S is S+1.
REQ-017 On a valid mismatching bit, the next S is the length of the longest proper prefix of PATTERN that is a suffix of the bits received so far (KMP fallback), never a blind return to 0.
REQ-018 On a detection with overlap_en=1, the next S is the longest proper border of PATTERN (for 10110, that is 2).
REQ-019 On a detection with overlap_en=0, the next S is 0.
REQ-020 overlap_en is sampled only in a detection cycle; changing it mid-sequence has no effect on partial-match progress.
REQ-021 match_cnt increments by 1 on each det_out=1 cycle and saturates at 2^CNT_W-1 without wrapping.
REQ-022 If cnt_clr=1 and det_out=1 in the same cycle, clear wins: match_cnt becomes 0.
REQ-023 All fallback targets are computed at elaboration from PATTERN; no runtime pattern storage.

Reset
REQ-024 While rst=1 at a rising clk edge: S becomes 0 and match_cnt becomes 0.
REQ-025 While rst=1, det_out is forced to 0 regardless of in_valid/in_seq.
REQ-026 rst asserted mid-sequence discards any partial match; the first valid bit after reset is treated as pattern bit 0.
REQ-027 rst has priority over cnt_clr and over detection.

Structure
REQ-028 Package seq_det_pkg holds: the elaboration-time function computing the KMP fallback table and border length from PATTERN/PAT_LEN; default constants for PAT_LEN, PATTERN and CNT_W.
REQ-029 Counter logic is a sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt), instantiated once.
REQ-030 Parameter legality (PAT_LEN range, CNT_W range) is checked by an elaboration-time assertion.

Verification (defaults PAT_LEN=5, PATTERN=10110, unless stated)
REQ-031 Non-overlap: rst, then overlap_en=0, stream 1,0,1,1,0,1,1,0 with in_valid=1 -> det_out=1 only on bit 5; match_cnt=1.
REQ-032 Overlap: same stream with overlap_en=1 -> det_out=1 on bits 5 and 8; match_cnt=2.
REQ-033 Fallback: stream 1,0,1,1,1,0,1,1,0 -> state_out=1 after bit 5; det_out=1 on bit 9 only.
REQ-034 Gaps and reset: stream 1,0,1 with in_valid low for 3 cycles between bits 2 and 3, then 1,0 -> detect on the final bit. A separate run: stream 1,0,1,1, rst for 1 cycle, then 0 -> no detect; state_out=0 after rst.
REQ-035 Counter: CNT_W=2, 4 detections -> match_cnt=3 (saturated); cnt_clr asserted in the same cycle as a detection -> match_cnt=0.
REQ-036 Alternate parameters: PAT_LEN=6, PATTERN=111010, stream 111010111010 with either overlap_en value -> det_out=1 on bits 6 and 12 (the border is 0).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parameterised sequence detector.
// The KMP tables are derived from the pattern, so no pattern storage is needed at runtime.
package seq_det_pkg;

   localparam int         DEF_PAT_LEN = 5;
   localparam logic [4:0] DEF_PATTERN = 5'b10110;
   localparam int         DEF_CNT_W   = 8;
   localparam int         MAX_PAT_LEN = 16;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_ADVANCE,
      STEP_FALLBACK,
      STEP_DETECT
   } stepKind_e;

   // Pattern bit idx in arrival order; the MSB of the pattern arrives first.
   function automatic logic patBit(input logic [15:0] pat, input int len, input int idx);
      return pat[4'(len - 1 - idx)];
   endfunction

   // Next matched-prefix length after receiving bit b while s bits are matched.
   // A full match (k == len) is excluded here because detection is handled separately.
   function automatic int kmpNext(input logic [15:0] pat, input int len, input int s, input logic b);
      int   best;
      logic ok;
      logic rx;
      best = 0;
      for (int k = 1; k <= s + 1; k++) begin
         if (k < len) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
               rx = ((s + 1 - k + i) == s) ? b : patBit(pat, len, s + 1 - k + i);
               if (rx != patBit(pat, len, i)) ok = 1'b0;
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   // Longest proper border of the whole pattern: where overlapping detection resumes.
   function automatic int borderLen(input logic [15:0] pat, input int len);
      int   best;
      logic ok;
      best = 0;
      for (int k = 1; k < len; k++) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++) begin
            if (patBit(pat, len, len - k + i) != patBit(pat, len, i)) ok = 1'b0;
         end
         if (ok) best = k;
      end
      return best;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   // Holds at all-ones instead of wrapping so a busy stream never reads as "few matches".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/seq_det_param_mealy.sv
// Mealy serial pattern detector with KMP fallback, selectable overlap and a saturating match counter.
module seq_det_param_mealy
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
   parameter int                 CNT_W   = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_seq,
   input  logic                       overlap_en,
   input  logic                       cnt_clr,
   output logic                       det_out,
   output logic [CNT_W-1:0]           match_cnt,
   output logic [$clog2(PAT_LEN)-1:0] state_out
);

   localparam int              SW       = $clog2(PAT_LEN);
   localparam int              NSTATE   = 2 ** SW;
   localparam logic [15:0]     PAT16    = 16'(PATTERN);
   localparam logic [SW-1:0]   LAST     = SW'(PAT_LEN - 1);
   localparam logic [SW-1:0]   BORDER_S = SW'(borderLen(PAT16, PAT_LEN));

   if ((PAT_LEN < 2) || (PAT_LEN > MAX_PAT_LEN) || (CNT_W < 1) || (CNT_W > 32)) begin : g_badParams
      $error("seq_det_param_mealy: PAT_LEN must be 2..16 and CNT_W must be 1..32");
   end

   logic [SW-1:0] w_next0 [NSTATE];
   logic [SW-1:0] w_next1 [NSTATE];
   logic [SW-1:0] w_lookup;
   logic          w_det;
   stepKind_e     w_step;
   logic [SW-1:0] r_state;

   // Unreachable encodings (when PAT_LEN is not a power of two) fall back to 0.
   for (genvar s = 0; s < NSTATE; s++) begin : g_tbl
      if (s < PAT_LEN) begin : g_live
         localparam int N0 = kmpNext(PAT16, PAT_LEN, s, 1'b0);
         localparam int N1 = kmpNext(PAT16, PAT_LEN, s, 1'b1);
         assign w_next0[s] = SW'(N0);
         assign w_next1[s] = SW'(N1);
      end else begin : g_dead
         assign w_next0[s] = '0;
         assign w_next1[s] = '0;
      end
   end

   // Classify this cycle's transition; detection is combinational so det_out has no latency.
   always_comb begin
      w_det    = 1'b0;
      w_step   = STEP_HOLD;
      w_lookup = in_seq ? w_next1[r_state] : w_next0[r_state];
      if (!rst && in_valid) begin
         if ((r_state == LAST) && (in_seq == PATTERN[0])) begin
            w_det  = 1'b1;
            w_step = STEP_DETECT;
         end else if (w_lookup == (r_state + 1'b1)) begin
            w_step = STEP_ADVANCE;
         end else begin
            w_step = STEP_FALLBACK;
         end
      end
   end

   // overlap_en only matters on a detection, so partial progress ignores it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= '0;
      end else begin
         case (w_step)
            STEP_ADVANCE:  r_state <= r_state + 1'b1;
            STEP_FALLBACK: r_state <= w_lookup;
            STEP_DETECT:   r_state <= overlap_en ? BORDER_S : '0;
            default:       r_state <= r_state;
         endcase
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_satCounter (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .inc(w_det),
      .cnt(match_cnt)
   );

   assign det_out   = w_det;
   assign state_out = r_state;

endmodule

// File: tb/tb_seq_det_param_mealy.sv
// Directed bench: default 10110 detector, a 2-bit-counter variant and a 111010 variant share one stimulus bus.
module tb_seq_det_param_mealy;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, inValid, inSeq, overlapEn, cntClr;
   logic       detA, detB, detC;
   logic [7:0] cntA, cntC;
   logic [1:0] cntB;
   logic [2:0] stA, stB, stC;
   logic       smpA, smpC;
   int         vecCount = 0;
   int         errCount = 0;

   seq_det_param_mealy dutA (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_seq(inSeq), .overlap_en(overlapEn),
      .cnt_clr(cntClr), .det_out(detA), .match_cnt(cntA), .state_out(stA)
   );

   seq_det_param_mealy #(.CNT_W(2)) dutB (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_seq(inSeq), .overlap_en(overlapEn),
      .cnt_clr(cntClr), .det_out(detB), .match_cnt(cntB), .state_out(stB)
   );

   seq_det_param_mealy #(.PAT_LEN(6), .PATTERN(6'b111010), .CNT_W(8)) dutC (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_seq(inSeq), .overlap_en(overlapEn),
      .cnt_clr(cntClr), .det_out(detC), .match_cnt(cntC), .state_out(stC)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle; det_out is sampled at the falling edge, state/count just after the rising edge.
   task automatic applyStimulus(input logic v, input logic b, input logic clr);
      inValid = v;
      inSeq   = b;
      cntClr  = clr;
      @(negedge clk);
      smpA = detA;
      smpC = detC;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      cntClr  = 1'b0;
   endtask

   task automatic runStream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] expDet, input int sel);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, bits[n-1-i], 1'b0);
         checkOutput($sformatf("%s det bit%0d", tag, i + 1), (sel == 2) ? smpC : smpA, expDet[n-1-i]);
      end
   endtask

   // Reset with a bit that would complete 1011x, so det_out must be held low by rst.
   task automatic doReset(input string tag);
      rst     = 1'b1;
      inValid = 1'b1;
      inSeq   = 1'b0;
      @(negedge clk);
      checkOutput({tag, " det in rst"}, detA, 1'b0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      inValid = 1'b0;
      checkOutput({tag, " state after rst"}, stA, 0);
      checkOutput({tag, " cnt after rst"}, cntA, 0);
   endtask

   initial begin
      rst = 1'b1; inValid = 1'b0; inSeq = 1'b0; overlapEn = 1'b0; cntClr = 1'b0;
      smpA = 1'b0; smpC = 1'b0;
      @(posedge clk);
      #1;
      doReset("init");
      checkOutput("init cntB", cntB, 0);
      checkOutput("init stC", stC, 0);

      overlapEn = 1'b0;
      runStream("nonovl", 16'b10110110, 8, 16'b00001000, 0);
      checkOutput("nonovl cnt", cntA, 1);
      checkOutput("nonovl state", stA, 2);

      doReset("ovl");
      overlapEn = 1'b1;
      runStream("ovl", 16'b10110110, 8, 16'b00001001, 0);
      checkOutput("ovl cnt", cntA, 2);
      checkOutput("ovl state", stA, 2);

      doReset("fallback");
      runStream("fbA", 16'b10111, 5, 16'b0, 0);
      checkOutput("fallback state bit5", stA, 1);
      runStream("fbB", 16'b0110, 4, 16'b0001, 0);

      doReset("gap");
      runStream("gapA", 16'b101, 3, 16'b0, 0);
      for (int g = 0; g < 3; g++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("gap det idle%0d", g), smpA, 1'b0);
      end
      checkOutput("gap state held", stA, 3);
      runStream("gapB", 16'b10, 2, 16'b01, 0);
      checkOutput("gap cnt", cntA, 1);

      doReset("midrst");
      runStream("midrst", 16'b1011, 4, 16'b0, 0);
      checkOutput("midrst state pre", stA, 4);
      doReset("midrst");
      runStream("postrst", 16'b0, 1, 16'b0, 0);
      checkOutput("postrst state", stA, 0);

      doReset("sat");
      overlapEn = 1'b1;
      runStream("sat", 16'b10110110110110, 14, 16'b00001001001001, 0);
      checkOutput("sat cntB", cntB, 3);
      checkOutput("sat cntA", cntA, 4);
      runStream("clrpre", 16'b11, 2, 16'b0, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("clr det same cycle", smpA, 1'b1);
      checkOutput("clr wins cntA", cntA, 0);
      checkOutput("clr wins cntB", cntB, 0);

      doReset("alt0");
      overlapEn = 1'b0;
      runStream("alt nonovl", 16'b111010111010, 12, 16'b000001000001, 2);
      checkOutput("alt nonovl cnt", cntC, 2);

      doReset("alt1");
      overlapEn = 1'b1;
      runStream("alt ovl", 16'b111010111010, 12, 16'b000001000001, 2);
      checkOutput("alt ovl cnt", cntC, 2);
      checkOutput("alt ovl state", stC, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
